// File: rtl/fpu_cordic_arith_pkg.sv
// Shared types and FP80 constants for the CORDIC arithmetic server.
package fpu_cordic_arith_pkg;

    // Per-channel handshake sequencing states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        RESPOND = 3'd3,
        HOLD    = 3'd4
    } chan_state_t;

    // x87 "indefinite" quiet NaN, returned when a unit never answers.
    localparam logic [79:0] FP80_QNAN_INDEF = 80'hFFFF_C000000000000000;

    // Handy constants for benches and directed tests.
    localparam logic [79:0] FP80_ZERO = 80'h0000_0000000000000000;
    localparam logic [79:0] FP80_ONE  = 80'h3FFF_8000000000000000;
    localparam logic [79:0] FP80_HALF = 80'h3FFE_8000000000000000;

endpackage

// File: rtl/fpu_arith_channel.sv
// One request/response channel: latches client operands, pulses the unit
// start, waits for the unit under a watchdog, and returns the result.
module fpu_arith_channel #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    // client side
    input  logic        req,
    input  logic [79:0] a,
    input  logic [79:0] b,
    input  logic        op,
    output logic [79:0] result,
    output logic        done,
    output logic        invalid,
    // unit side
    output logic        unit_start,
    output logic [79:0] unit_a,
    output logic [79:0] unit_b,
    output logic        unit_op,
    input  logic [79:0] unit_result,
    input  logic        unit_done,
    input  logic        unit_invalid,
    // single-cycle pulse when the watchdog expires
    output logic        timeout_pulse
);
    import fpu_cordic_arith_pkg::*;

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    chan_state_t state, next_state;
    logic [7:0]  watchdog;
    logic [79:0] result_q;
    logic        invalid_q;
    logic [79:0] a_q, b_q;
    logic        op_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values and the
            // order of always_ff blocks cannot change behaviour.
            state <= next_state;
        end
    end

    // Operand latch, watchdog and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= FP80_ZERO;
            b_q       <= FP80_ZERO;
            op_q      <= 1'b0;
            watchdog  <= 8'd0;
            result_q  <= FP80_ZERO;
            invalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op;
                    end
                end
                ISSUE: begin
                    watchdog <= 8'd0;
                    if (unit_done) begin
                        result_q  <= unit_result;
                        invalid_q <= unit_invalid;
                    end
                end
                WAIT: begin
                    if (unit_done) begin
                        result_q  <= unit_result;
                        invalid_q <= unit_invalid;
                    end else if (watchdog == WD_LIMIT) begin
                        result_q  <= FP80_QNAN_INDEF;
                        invalid_q <= 1'b1;
                    end else begin
                        watchdog <= watchdog + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and decoded strobes; unit done outside ISSUE/WAIT is ignored.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        next_state    = state;
        unit_start    = 1'b0;
        done          = 1'b0;
        timeout_pulse = 1'b0;
        case (state)
            IDLE:    if (req) next_state = ISSUE;
            ISSUE: begin
                unit_start = 1'b1;
                next_state = unit_done ? RESPOND : WAIT;
            end
            WAIT: begin
                if (unit_done) begin
                    next_state = RESPOND;
                end else if (watchdog == WD_LIMIT) begin
                    next_state    = RESPOND;
                    timeout_pulse = 1'b1;
                end
            end
            RESPOND: begin
                done       = 1'b1;
                next_state = HOLD;
            end
            HOLD:    if (!req) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign result  = result_q;
    assign invalid = invalid_q;
    assign unit_a  = a_q;
    assign unit_b  = b_q;
    assign unit_op = op_q;

endmodule

// File: rtl/fpu_cordic_arith_server.sv
// Responder for the CORDIC wrapper's external add/sub and mul/div requests:
// two independent channels plus a sticky timeout flag.
module fpu_cordic_arith_server #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_addsub_req,
    input  logic [79:0] ext_addsub_a,
    input  logic [79:0] ext_addsub_b,
    input  logic        ext_addsub_sub,
    output logic [79:0] ext_addsub_result,
    output logic        ext_addsub_done,
    output logic        ext_addsub_invalid,
    input  logic        ext_muldiv_req,
    input  logic        ext_muldiv_op,
    input  logic [79:0] ext_muldiv_a,
    input  logic [79:0] ext_muldiv_b,
    output logic [79:0] ext_muldiv_result,
    output logic        ext_muldiv_done,
    output logic        ext_muldiv_invalid,
    output logic        addsub_start,
    output logic [79:0] addsub_a,
    output logic [79:0] addsub_b,
    output logic        addsub_sub,
    input  logic [79:0] addsub_result,
    input  logic        addsub_done,
    input  logic        addsub_invalid,
    output logic        muldiv_start,
    output logic        muldiv_op,
    output logic [79:0] muldiv_a,
    output logic [79:0] muldiv_b,
    input  logic [79:0] muldiv_result,
    input  logic        muldiv_done,
    input  logic        muldiv_invalid,
    output logic        timeout_flag
);
    logic addsub_timeout;
    logic muldiv_timeout;

    fpu_arith_channel #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_addsub (
        .clk(clk), .reset(reset),
        .req(ext_addsub_req), .a(ext_addsub_a), .b(ext_addsub_b), .op(ext_addsub_sub),
        .result(ext_addsub_result), .done(ext_addsub_done), .invalid(ext_addsub_invalid),
        .unit_start(addsub_start), .unit_a(addsub_a), .unit_b(addsub_b), .unit_op(addsub_sub),
        .unit_result(addsub_result), .unit_done(addsub_done), .unit_invalid(addsub_invalid),
        .timeout_pulse(addsub_timeout)
    );

    fpu_arith_channel #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_muldiv (
        .clk(clk), .reset(reset),
        .req(ext_muldiv_req), .a(ext_muldiv_a), .b(ext_muldiv_b), .op(ext_muldiv_op),
        .result(ext_muldiv_result), .done(ext_muldiv_done), .invalid(ext_muldiv_invalid),
        .unit_start(muldiv_start), .unit_a(muldiv_a), .unit_b(muldiv_b), .unit_op(muldiv_op),
        .unit_result(muldiv_result), .unit_done(muldiv_done), .unit_invalid(muldiv_invalid),
        .timeout_pulse(muldiv_timeout)
    );

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (addsub_timeout || muldiv_timeout) begin
            timeout_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_cordic_arith_server.sv
// Directed bench for fpu_cordic_arith_server with TIMEOUT_CYCLES = 16.
module tb_fpu_cordic_arith_server;
    import fpu_cordic_arith_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ext_addsub_req, ext_addsub_sub;
    logic [79:0] ext_addsub_a, ext_addsub_b, ext_addsub_result;
    logic        ext_addsub_done, ext_addsub_invalid;
    logic        ext_muldiv_req, ext_muldiv_op;
    logic [79:0] ext_muldiv_a, ext_muldiv_b, ext_muldiv_result;
    logic        ext_muldiv_done, ext_muldiv_invalid;
    logic        addsub_start, addsub_sub;
    logic [79:0] addsub_a, addsub_b, addsub_result;
    logic        addsub_done, addsub_invalid;
    logic        muldiv_start, muldiv_op;
    logic [79:0] muldiv_a, muldiv_b, muldiv_result;
    logic        muldiv_done, muldiv_invalid;
    logic        timeout_flag;

    int checks   = 0;
    int failures = 0;

    localparam logic [79:0] AS_A   = 80'h3FFF_8000000000000000;
    localparam logic [79:0] AS_B   = 80'h3FFE_8000000000000000;
    localparam logic [79:0] AS_R   = 80'h3FFF_C000000000000000;
    localparam logic [79:0] MD_A   = 80'h3FFF_8000000000000000;
    localparam logic [79:0] MD_B   = 80'h4000_8000000000000000;
    localparam logic [79:0] MD_R   = 80'h3FFE_8000000000000000;
    localparam logic [79:0] AS_R2  = 80'h4000_A000000000000000;
    localparam logic [79:0] MD_R2  = 80'h3FFD_C000000000000000;
    localparam logic [79:0] JUNK   = 80'h1234_5678_9ABC_DEF0_1111;
    localparam logic [79:0] LATE_R = 80'h4001_8000000000000000;

    fpu_cordic_arith_server #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .ext_addsub_req(ext_addsub_req), .ext_addsub_a(ext_addsub_a),
        .ext_addsub_b(ext_addsub_b), .ext_addsub_sub(ext_addsub_sub),
        .ext_addsub_result(ext_addsub_result), .ext_addsub_done(ext_addsub_done),
        .ext_addsub_invalid(ext_addsub_invalid),
        .ext_muldiv_req(ext_muldiv_req), .ext_muldiv_op(ext_muldiv_op),
        .ext_muldiv_a(ext_muldiv_a), .ext_muldiv_b(ext_muldiv_b),
        .ext_muldiv_result(ext_muldiv_result), .ext_muldiv_done(ext_muldiv_done),
        .ext_muldiv_invalid(ext_muldiv_invalid),
        .addsub_start(addsub_start), .addsub_a(addsub_a), .addsub_b(addsub_b),
        .addsub_sub(addsub_sub), .addsub_result(addsub_result),
        .addsub_done(addsub_done), .addsub_invalid(addsub_invalid),
        .muldiv_start(muldiv_start), .muldiv_op(muldiv_op), .muldiv_a(muldiv_a),
        .muldiv_b(muldiv_b), .muldiv_result(muldiv_result),
        .muldiv_done(muldiv_done), .muldiv_invalid(muldiv_invalid),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        ext_addsub_req = 0; ext_addsub_sub = 0; ext_addsub_a = '0; ext_addsub_b = '0;
        ext_muldiv_req = 0; ext_muldiv_op = 0; ext_muldiv_a = '0; ext_muldiv_b = '0;
        addsub_result = '0; addsub_done = 0; addsub_invalid = 0;
        muldiv_result = '0; muldiv_done = 0; muldiv_invalid = 0;

        // ---- reset state ----
        step(); step();
        check("rst_as_done",   80'(ext_addsub_done), 80'(0));
        check("rst_md_done",   80'(ext_muldiv_done), 80'(0));
        check("rst_as_start",  80'(addsub_start), 80'(0));
        check("rst_md_start",  80'(muldiv_start), 80'(0));
        check("rst_as_inv",    80'(ext_addsub_invalid), 80'(0));
        check("rst_as_result", ext_addsub_result, FP80_ZERO);
        check("rst_md_a",      muldiv_a, FP80_ZERO);
        check("rst_tflag",     80'(timeout_flag), 80'(0));
        reset = 1'b0;
        step();

        // ---- add/sub, unit latency 5: client done 7 cycles after req ----
        ext_addsub_a = AS_A; ext_addsub_b = AS_B; ext_addsub_sub = 0; ext_addsub_req = 1;
        step();
        check("as_start_c1", 80'(addsub_start), 80'(1));
        check("as_unit_a",   addsub_a, AS_A);
        check("as_unit_b",   addsub_b, AS_B);
        check("as_unit_sub", 80'(addsub_sub), 80'(0));
        ext_addsub_a = JUNK;
        for (int c = 2; c <= 6; c++) begin
            step();
            check($sformatf("as_start_c%0d", c), 80'(addsub_start), 80'(0));
            check($sformatf("as_done_c%0d", c), 80'(ext_addsub_done), 80'(0));
        end
        addsub_done = 1; addsub_result = AS_R; addsub_invalid = 0;
        step();
        check("as_done_c7",   80'(ext_addsub_done), 80'(1));
        check("as_result",    ext_addsub_result, AS_R);
        check("as_invalid",   80'(ext_addsub_invalid), 80'(0));
        check("as_a_held",    addsub_a, AS_A);
        addsub_done = 0; ext_addsub_req = 0;
        step();
        check("as_done_c8",   80'(ext_addsub_done), 80'(0));
        check("as_result_c8", ext_addsub_result, AS_R);
        step();

        // ---- divide, unit latency 8: client done at cycle 10 ----
        ext_muldiv_a = MD_A; ext_muldiv_b = MD_B; ext_muldiv_op = 1; ext_muldiv_req = 1;
        step();
        check("md_start_c1", 80'(muldiv_start), 80'(1));
        check("md_unit_op",  80'(muldiv_op), 80'(1));
        check("md_unit_b",   muldiv_b, MD_B);
        for (int c = 2; c <= 9; c++) begin
            step();
            check($sformatf("md_done_c%0d", c), 80'(ext_muldiv_done), 80'(0));
        end
        muldiv_done = 1; muldiv_result = MD_R;
        step();
        check("md_done_c10", 80'(ext_muldiv_done), 80'(1));
        check("md_result",   ext_muldiv_result, MD_R);
        check("md_invalid",  80'(ext_muldiv_invalid), 80'(0));
        muldiv_done = 0; ext_muldiv_req = 0;
        step(); step();

        // ---- simultaneous requests, latencies 5 and 8 ----
        ext_addsub_a = AS_B; ext_addsub_b = AS_A; ext_addsub_sub = 1; ext_addsub_req = 1;
        ext_muldiv_a = MD_B; ext_muldiv_b = MD_A; ext_muldiv_op = 0; ext_muldiv_req = 1;
        step();
        check("sim_as_start", 80'(addsub_start), 80'(1));
        check("sim_md_start", 80'(muldiv_start), 80'(1));
        check("sim_as_sub",   80'(addsub_sub), 80'(1));
        check("sim_md_op",    80'(muldiv_op), 80'(0));
        for (int c = 2; c <= 10; c++) begin
            step();
            check($sformatf("sim_as_done_c%0d", c), 80'(ext_addsub_done), 80'(c == 7));
            check($sformatf("sim_md_done_c%0d", c), 80'(ext_muldiv_done), 80'(c == 10));
            check($sformatf("sim_starts_c%0d", c), 80'({addsub_start, muldiv_start}), 80'(0));
            if (c == 7) check("sim_as_result", ext_addsub_result, AS_R2);
            if (c == 10) begin
                check("sim_md_result",    ext_muldiv_result, MD_R2);
                check("sim_as_result_hd", ext_addsub_result, AS_R2);
            end
            if (c == 6) begin addsub_done = 1; addsub_result = AS_R2; end
            if (c == 7) begin addsub_done = 0; ext_addsub_req = 0; end
            if (c == 9) begin muldiv_done = 1; muldiv_result = MD_R2; end
            if (c == 10) begin muldiv_done = 0; ext_muldiv_req = 0; end
        end
        step(); step();

        // ---- timeout: unit never answers; done 17 cycles after start ----
        ext_addsub_a = AS_A; ext_addsub_b = AS_B; ext_addsub_sub = 0; ext_addsub_req = 1;
        step();
        check("to_start_c1", 80'(addsub_start), 80'(1));
        for (int c = 2; c <= 17; c++) begin
            step();
            check($sformatf("to_done_c%0d", c), 80'(ext_addsub_done), 80'(0));
            check($sformatf("to_flag_c%0d", c), 80'(timeout_flag), 80'(0));
        end
        step();
        check("to_done_c18", 80'(ext_addsub_done), 80'(1));
        check("to_result",   ext_addsub_result, 80'hFFFF_C000000000000000);
        check("to_invalid",  80'(ext_addsub_invalid), 80'(1));
        check("to_flag",     80'(timeout_flag), 80'(1));
        ext_addsub_req = 0;
        step();
        addsub_done = 1; addsub_result = LATE_R;
        step();
        addsub_done = 0;
        check("late_done",    80'(ext_addsub_done), 80'(0));
        check("late_start",   80'(addsub_start), 80'(0));
        check("late_result",  ext_addsub_result, 80'hFFFF_C000000000000000);
        step();
        check("late_done2",   80'(ext_addsub_done), 80'(0));
        check("late_flag",    80'(timeout_flag), 80'(1));

        // ---- zero-latency unit, then req held high after done ----
        ext_muldiv_a = MD_A; ext_muldiv_b = MD_B; ext_muldiv_op = 0; ext_muldiv_req = 1;
        step();
        check("hold_start_c1", 80'(muldiv_start), 80'(1));
        muldiv_done = 1; muldiv_result = AS_R;
        step();
        muldiv_done = 0;
        check("zl_done_c2",   80'(ext_muldiv_done), 80'(1));
        check("zl_result",    ext_muldiv_result, AS_R);
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("held_start_%0d", c), 80'(muldiv_start), 80'(0));
            check($sformatf("held_done_%0d", c), 80'(ext_muldiv_done), 80'(0));
        end
        ext_muldiv_req = 0;
        step();
        check("drop_start", 80'(muldiv_start), 80'(0));
        ext_muldiv_a = MD_B; ext_muldiv_req = 1;
        step();
        check("rereq_start", 80'(muldiv_start), 80'(1));
        check("rereq_a",     muldiv_a, MD_B);
        step();
        muldiv_done = 1; muldiv_result = MD_R2;
        step();
        muldiv_done = 0; ext_muldiv_req = 0;
        check("rereq_done",   80'(ext_muldiv_done), 80'(1));
        check("rereq_result", ext_muldiv_result, MD_R2);
        step(); step();

        // ---- reset while waiting ----
        ext_addsub_a = AS_B; ext_addsub_req = 1;
        step(); step(); step();
        reset = 1'b1;
        #1;
        check("rw_as_done",   80'(ext_addsub_done), 80'(0));
        check("rw_as_start",  80'(addsub_start), 80'(0));
        check("rw_as_result", ext_addsub_result, FP80_ZERO);
        check("rw_as_inv",    80'(ext_addsub_invalid), 80'(0));
        check("rw_as_a",      addsub_a, FP80_ZERO);
        check("rw_tflag",     80'(timeout_flag), 80'(0));
        check("rw_md_result", ext_muldiv_result, FP80_ZERO);
        ext_addsub_req = 0;
        step();
        reset = 1'b0;
        addsub_done = 1; addsub_result = LATE_R;
        step();
        addsub_done = 0;
        check("rw_post_done1", 80'(ext_addsub_done), 80'(0));
        step();
        check("rw_post_done2", 80'(ext_addsub_done), 80'(0));
        check("rw_post_res",   ext_addsub_result, FP80_ZERO);

        // new request after reset, unit latency 2: client done at cycle 4
        ext_addsub_a = AS_A; ext_addsub_b = AS_A; ext_addsub_sub = 0; ext_addsub_req = 1;
        step();
        check("new_start", 80'(addsub_start), 80'(1));
        check("new_a",     addsub_a, AS_A);
        step(); step();
        addsub_done = 1; addsub_result = 80'h4000_8000000000000000; addsub_invalid = 0;
        step();
        addsub_done = 0; ext_addsub_req = 0;
        check("new_done",   80'(ext_addsub_done), 80'(1));
        check("new_result", ext_addsub_result, 80'h4000_8000000000000000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_cordic_arith_server.md
# fpu_cordic_arith_server

Responder side of the CORDIC wrapper's external arithmetic interface. It accepts level-held `ext_addsub_req` and `ext_muldiv_req` requests from `FPU_CORDIC_Wrapper` and latches their operands. It issues one-cycle start pulses to the shared FP80 add/sub and mul/div units, then returns each result with a one-cycle done pulse. Each channel has a watchdog that converts a hung unit into an invalid response, so the CORDIC sequencer never deadlocks.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum cycles to wait for a unit `done` after `start`. Range 2..255.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `ext_addsub_req`  in  1  client add/sub request, level, held until `ext_addsub_done`
- `ext_addsub_a`, `ext_addsub_b`  in  80  FP80 operands
- `ext_addsub_sub`  in  1  1 = a−b, 0 = a+b
- `ext_addsub_result`  out  80  registered result
- `ext_addsub_done`  out  1  one-cycle completion pulse
- `ext_addsub_invalid`  out  1  valid only with done
- `ext_muldiv_req`  in  1  client mul/div request, level
- `ext_muldiv_op`  in  1  0 = multiply, 1 = divide
- `ext_muldiv_a`, `ext_muldiv_b`  in  80  FP80 operands
- `ext_muldiv_result`  out  80
- `ext_muldiv_done`  out  1
- `ext_muldiv_invalid`  out  1
- `addsub_start`  out  1  one-cycle start to the add/sub unit
- `addsub_a`, `addsub_b`  out  80  latched operands
- `addsub_sub`  out  1  latched op
- `addsub_result`  in  80
- `addsub_done`  in  1
- `addsub_invalid`  in  1
- `muldiv_start`, `muldiv_op`, `muldiv_a`, `muldiv_b`, `muldiv_result`, `muldiv_done`, `muldiv_invalid`: same pattern for the mul/div unit.
- `timeout_flag`  out  1  sticky; set by any channel timeout, cleared only by reset

## Operation
- Two independent, identical channels. Both may be busy at once; there is no arbitration between them.
- Channel FSM states: IDLE, ISSUE, WAIT, RESPOND, HOLD.
  - IDLE: when `req`=1, latch a, b and op, go to ISSUE.
  - ISSUE: `start`=1 for exactly one cycle. Clear the watchdog. Go to WAIT; if unit `done`=1 in this same cycle, go to RESPOND.
  - WAIT: increment the watchdog each cycle.
    - On unit `done`: register `result` and `invalid`, go to RESPOND.
    - When the watchdog reaches TIMEOUT_CYCLES−1 with no done: result = 80'hFFFF_C000000000000000 (QNaN indefinite), invalid = 1, set `timeout_flag`, go to RESPOND.
  - RESPOND: client `done`=1 for one cycle. Go to HOLD.
  - HOLD: stay until `req`=0, then go to IDLE. A request held high after done is never re-issued; the client must drop `req` for at least one cycle between operations.
- Unit `done` arriving outside ISSUE/WAIT (late or spurious) is ignored.
- Unit-side operand outputs hold the latched values from ISSUE until the next latch. Client operand changes during a busy channel have no effect.
- Reset values: every `*_done`, `*_start`, `*_invalid` and `timeout_flag` = 0; results and unit operands = 0; both FSMs IDLE; watchdogs = 0.
- Reset mid-operation returns the channel to IDLE immediately and the result is dropped. A unit `done` that follows reset is ignored.

## Timing
- `req` sampled high at edge 0 → `start` high cycle 1 → unit `done` at edge k → client `done` high in the cycle after edge k.
- Total client latency = unit latency + 2 cycles.
- Zero-latency unit (done in the ISSUE cycle): client done in cycle 2.
- Timeout: client done exactly TIMEOUT_CYCLES+1 cycles after `start`.
- `result` and `invalid` are stable from the done cycle until the next RESPOND.
- Minimum issue interval per channel is 4 cycles plus the HOLD dwell.

## Structure
- Shared package `fpu_cordic_arith_pkg`:
  - `chan_state_t` enum (IDLE, ISSUE, WAIT, RESPOND, HOLD)
  - `FP80_QNAN_INDEF`
  - `FP80_ZERO`, `FP80_ONE`, `FP80_HALF` for benches
- Sub-module `fpu_arith_channel`: one FSM, operand/op latch, watchdog, result register; instantiated twice. `TIMEOUT_CYCLES` passes through. The top level only maps ports and ORs the per-channel timeout pulses into the sticky `timeout_flag`.

## Test plan
- Add/sub: req with a=3FFF_8000000000000000, b=3FFE_8000000000000000, sub=0; unit model latency 5 returns 3FFF_C000000000000000 → single `addsub_start`, client done 7 cycles after req, result 3FFF_C000000000000000, invalid 0.
- Divide: op=1, a=3FFF_8…, b=4000_8…; model returns 3FFE_8000000000000000 at latency 8 → `muldiv_op`=1 at the unit, done at cycle 10, correct result.
- Simultaneous: both reqs asserted on the same edge with different latencies (5, 8) → both starts in cycle 1, dones at cycles 7 and 10, no cross-talk between results.
- Timeout: TIMEOUT_CYCLES=16, unit never answers → done 17 cycles after start, result FFFF_C000000000000000, invalid 1, `timeout_flag` stays 1. A late unit `done` afterwards is ignored.
- Held req: client keeps req high for 20 cycles after done → exactly one `start`. Drop req for one cycle, re-raise → second start.
- Reset in WAIT: assert reset mid-wait → all outputs 0 that cycle. The unit's subsequent `done` produces no client done. A new request after reset completes normally.
